// File: rtl/fwd_sel_gen_pkg.sv
// Shared definitions for the forwarding-select generator: select codes,
// the shadow pipeline slot record and the slot match helper.
package fwd_sel_gen_pkg;

    // Register numbers are carried zero-extended to this width inside slots,
    // so the record type does not depend on the REGW parameter.
    localparam int REGW_MAX = 16;

    localparam logic [2:0] SEL_RF = 3'd0;
    localparam logic [2:0] SEL_S1 = 3'd1;
    localparam logic [2:0] SEL_S2 = 3'd2;
    localparam logic [2:0] SEL_S3 = 3'd3;

    typedef struct packed {
        logic                valid;
        logic                wr_en;
        logic [REGW_MAX-1:0] wr_reg;
        logic                is_load;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    // Register 0 is hardwired, so a producer of $0 never forwards.
    function automatic logic slot_match(input slot_t s, input logic [REGW_MAX-1:0] r);
        return s.valid && s.wr_en && (s.wr_reg == r) && (r != '0);
    endfunction

endpackage

// File: rtl/fwd_sel_gen_fwd_match.sv
// Compares one ID source register against the EX/MEM/WB shadow slots and
// returns the forwarding select (youngest producer wins) plus a load hit on S1.
module fwd_match
    import fwd_sel_gen_pkg::*;
#(
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] src,
    input  logic            used,
    input  slot_t           s1,
    input  slot_t           s2,
    input  slot_t           s3,
    output logic [2:0]      sel,
    output logic            load_hit
);

    logic [REGW_MAX-1:0] src_ext;
    logic                m1;
    logic                m2;
    logic                m3;

    assign src_ext = REGW_MAX'(src);
    assign m1      = used && slot_match(s1, src_ext);
    assign m2      = used && slot_match(s2, src_ext);
    assign m3      = used && slot_match(s3, src_ext);

    always_comb begin
        sel = SEL_RF;
        if (m1)      sel = SEL_S1;
        else if (m2) sel = SEL_S2;
        else if (m3) sel = SEL_S3;
    end

    assign load_hit = m1 && s1.is_load;

endmodule

// File: rtl/fwd_sel_gen.sv
// Forwarding-select and load-use stall generator for a 5-stage pipeline.
// Optional saturating event counters are built when FWD_STATS_EN is defined.
module fwd_sel_gen
    import fwd_sel_gen_pkg::*;
#(
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_rs_used,
    input  logic            id_rt_used,
    input  logic            id_wr_en,
    input  logic [REGW-1:0] id_wr_reg,
    input  logic            id_is_load,
    input  logic            flush,
    output logic            stall,
    output logic [2:0]      sel_a,
    output logic [2:0]      sel_b,
`ifdef FWD_STATS_EN
    output logic [15:0]     stall_cnt,
    output logic [15:0]     fwd_cnt,
`endif
    output logic            mux_dis
);

    slot_t      s1;
    slot_t      s2;
    slot_t      s3;
    slot_t      id_slot;
    logic [2:0] sel_a_c;
    logic [2:0] sel_b_c;
    logic       hit_a;
    logic       hit_b;
    logic       issue;

    fwd_match #(.REGW(REGW)) u_match_a (
        .src      (id_rs),
        .used     (id_rs_used),
        .s1       (s1),
        .s2       (s2),
        .s3       (s3),
        .sel      (sel_a_c),
        .load_hit (hit_a)
    );

    fwd_match #(.REGW(REGW)) u_match_b (
        .src      (id_rt),
        .used     (id_rt_used),
        .s1       (s1),
        .s2       (s2),
        .s3       (s3),
        .sel      (sel_b_c),
        .load_hit (hit_b)
    );

    always_comb begin
        id_slot         = SLOT_BUBBLE;
        id_slot.valid   = 1'b1;
        id_slot.wr_en   = id_wr_en;
        id_slot.wr_reg  = REGW_MAX'(id_wr_reg);
        id_slot.is_load = id_is_load;
    end

    // Gated by rst_n so the request is quiet while slots are still undefined.
    assign stall = rst_n && id_valid && !flush && (hit_a || hit_b);
    assign issue = id_valid && !flush && !stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1      <= SLOT_BUBBLE;
            s2      <= SLOT_BUBBLE;
            s3      <= SLOT_BUBBLE;
            sel_a   <= SEL_RF;
            sel_b   <= SEL_RF;
            mux_dis <= 1'b1;
        end else begin
            s1      <= issue ? id_slot : SLOT_BUBBLE;
            s2      <= s1;
            s3      <= s2;
            sel_a   <= issue ? sel_a_c : SEL_RF;
            sel_b   <= issue ? sel_b_c : SEL_RF;
            mux_dis <= !issue;
        end
    end

`ifdef FWD_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (issue && ((sel_a_c != SEL_RF) || (sel_b_c != SEL_RF)) && (fwd_cnt != 16'hFFFF))
                fwd_cnt <= fwd_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_sel_gen.sv
// Directed bench for fwd_sel_gen: forwarding priority, load-use stall,
// flush override, register-0 handling and reset behaviour.
module tb_fwd_sel_gen;

    localparam int REGW = 5;

    logic            clk;
    logic            rst_n;
    logic            id_valid;
    logic [REGW-1:0] id_rs;
    logic [REGW-1:0] id_rt;
    logic            id_rs_used;
    logic            id_rt_used;
    logic            id_wr_en;
    logic [REGW-1:0] id_wr_reg;
    logic            id_is_load;
    logic            flush;
    logic            stall;
    logic [2:0]      sel_a;
    logic [2:0]      sel_b;
    logic            mux_dis;
`ifdef FWD_STATS_EN
    logic [15:0]     stall_cnt;
    logic [15:0]     fwd_cnt;
`endif

    int n_checks;
    int n_fail;

    fwd_sel_gen #(.REGW(REGW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .id_wr_en   (id_wr_en),
        .id_wr_reg  (id_wr_reg),
        .id_is_load (id_is_load),
        .flush      (flush),
        .stall      (stall),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
`ifdef FWD_STATS_EN
        .stall_cnt  (stall_cnt),
        .fwd_cnt    (fwd_cnt),
`endif
        .mux_dis    (mux_dis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // valid, rs, rs_used, rt, rt_used, wr_en, wr_reg, is_load, flush
    task automatic set_id(input logic v, input logic [REGW-1:0] rs, input logic rsu,
                          input logic [REGW-1:0] rt, input logic rtu, input logic we,
                          input logic [REGW-1:0] wr, input logic ld, input logic fl);
        id_valid   = v;
        id_rs      = rs;
        id_rs_used = rsu;
        id_rt      = rt;
        id_rt_used = rtu;
        id_wr_en   = we;
        id_wr_reg  = wr;
        id_is_load = ld;
        flush      = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] ea, input logic [2:0] eb, input logic ed);
        chk({tag, ".sel_a"}, 16'(sel_a), 16'(ea));
        chk({tag, ".sel_b"}, 16'(sel_b), 16'(eb));
        chk({tag, ".mux_dis"}, 16'(mux_dis), 16'(ed));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_stall_during", 16'(stall), 16'd0);
        tick();
        tick();
        chk_out("rst", 3'd0, 3'd0, 1'b1);
        chk("rst_stall", 16'(stall), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // add $5 <- $1,$2 ; then consumer of $5 (forward from EX)
        set_id(1, 1, 1, 2, 1, 1, 5, 0, 0);
        tick();
        chk_out("add5", 3'd0, 3'd0, 1'b0);
        set_id(1, 5, 1, 6, 1, 1, 7, 0, 0);
        chk("use5_stall", 16'(stall), 16'd0);
        tick();
        chk_out("use5", 3'd1, 3'd0, 1'b0);
        // S1=$7, S2=$5
        set_id(1, 5, 1, 7, 1, 0, 0, 0, 0);
        chk("s2s1_stall", 16'(stall), 16'd0);
        tick();
        chk_out("s2s1", 3'd2, 3'd1, 1'b0);
        // S2=$7, S3=$5
        set_id(1, 5, 1, 7, 1, 0, 0, 0, 0);
        tick();
        chk_out("s3s2", 3'd3, 3'd2, 1'b0);

        // three producers of $3: youngest wins; both operands same slot
        for (int i = 0; i < 3; i++) begin
            set_id(1, 0, 0, 0, 0, 1, 3, 0, 0);
            tick();
        end
        set_id(1, 3, 1, 3, 1, 0, 0, 0, 0);
        chk("dup3_stall", 16'(stall), 16'd0);
        tick();
        chk_out("dup3", 3'd1, 3'd1, 1'b0);

        // register 0 never matches, not even for a load
        set_id(1, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        set_id(1, 0, 1, 0, 0, 1, 0, 1, 0);
        tick();
        chk_out("r0_alu", 3'd0, 3'd0, 1'b0);
        set_id(1, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("r0_load_stall", 16'(stall), 16'd0);
        tick();
        chk_out("r0_load", 3'd0, 3'd0, 1'b0);

        // load-use on rt: one stall cycle, bubble, then forward from MEM
        set_id(1, 0, 0, 0, 0, 1, 8, 1, 0);
        tick();
        set_id(1, 1, 1, 8, 1, 0, 0, 0, 0);
        chk("lu_stall1", 16'(stall), 16'd1);
        tick();
        chk_out("lu_bubble", 3'd0, 3'd0, 1'b1);
        chk("lu_stall2", 16'(stall), 16'd0);
        tick();
        chk_out("lu_fwd", 3'd0, 3'd2, 1'b0);

        // load-use hazard with flush in the same cycle
        set_id(1, 0, 0, 0, 0, 1, 9, 1, 0);
        tick();
        set_id(1, 9, 1, 0, 0, 0, 0, 0, 1);
        chk("fl_stall", 16'(stall), 16'd0);
        tick();
        chk_out("fl", 3'd0, 3'd0, 1'b1);
        set_id(1, 9, 1, 0, 0, 0, 0, 0, 0);
        chk("fl_next_stall", 16'(stall), 16'd0);
        tick();
        chk_out("fl_next", 3'd2, 3'd0, 1'b0);

`ifdef FWD_STATS_EN
        chk("stall_cnt", stall_cnt, 16'd1);
        chk("fwd_cnt", fwd_cnt, 16'd6);
`endif

        // no valid instruction gives a bubble
        set_id(0, 9, 1, 9, 1, 1, 4, 0, 0);
        tick();
        chk_out("idle", 3'd0, 3'd0, 1'b1);

        // reset during a stall
        set_id(1, 0, 0, 0, 0, 1, 10, 1, 0);
        tick();
        set_id(1, 10, 1, 0, 0, 0, 0, 0, 0);
        chk("rs_stall_pre", 16'(stall), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("rs_stall_in", 16'(stall), 16'd0);
        tick();
        chk_out("rs", 3'd0, 3'd0, 1'b1);
        chk("rs_stall_post", 16'(stall), 16'd0);
`ifdef FWD_STATS_EN
        chk("stall_cnt_rst", stall_cnt, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        set_id(1, 10, 1, 10, 1, 0, 0, 0, 0);
        chk("post_rst_stall", 16'(stall), 16'd0);
        tick();
        chk_out("post_rst", 3'd0, 3'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_sel_gen.md
FWD_SEL_GEN -- requirements
Module: fwd_sel_gen

Interface
REQ-001 Parameter: REGW, default 5, register-number width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 id_valid  input  1  ID stage holds a real instruction.
REQ-005 id_rs, id_rt  input  REGW each  ID source register numbers.
REQ-006 id_rs_used, id_rt_used  input  1 each  source actually read.
REQ-007 id_wr_en, id_wr_reg, id_is_load  input  1/REGW/1  ID instruction's destination info.
REQ-008 flush  input  1  redirect from branch/jump; kills ID instruction.
REQ-009 stall  output  1  combinational load-use stall request to PC/IF/ID latches.
REQ-010 sel_a, sel_b  output  3 each  registered forwarding selects for EX-stage 8:1 operand muxes (addr).
REQ-011 mux_dis  output  1  registered; 1 forces EX operand muxes to output zero (enable pin).
REQ-012 With FWD_STATS_EN: stall_cnt, fwd_cnt  output  16 each  saturating event counters.

Function
REQ-013 Block keeps shadow slots S1, S2, S3 (EX, MEM, WB), each {valid, wr_en, wr_reg, is_load}.
REQ-014 Slot "matches" source r when valid && wr_en && wr_reg==r && r!=0; register 0 never matches.
REQ-015 stall = id_valid && !flush && S1 is_load && S1 matches a used ID source.
REQ-016 Select encoding: 0 regfile, 1 S1 result, 2 S2 result, 3 S3 result; 4-7 never driven.
REQ-017 Priority per operand: S1 over S2 over S3 over regfile (youngest producer wins).
REQ-018 Unused source (rs_used/rt_used low) yields select 0.
REQ-019 Each edge, when stall=0: S1<=ID info if id_valid&&!flush else bubble; S2<=S1; S3<=S2.
REQ-020 When stall=1: S1<=bubble; S2<=S1; S3<=S2; ID instruction is held and re-evaluated next cycle.
REQ-021 sel_a/sel_b/mux_dis register on same edge as S1: values for instruction entering EX.
REQ-022 mux_dis<=1 whenever S1 is loaded with a bubble (stall, flush or !id_valid); else 0.
REQ-023 Latency: one cycle from ID inputs to sel/mux_dis; stall has zero latency.
REQ-024 Load-use resolves with exactly one stall cycle; following cycle selects 2 for the load's consumer.
REQ-025 flush and stall same cycle: flush wins; stall output forced 0.
REQ-026 Both operands matching same slot give identical selects; no extra stall.

Reset
REQ-027 rst_n low at edge: S1-S3 invalid, sel_a=sel_b=0, mux_dis=1, counters 0.
REQ-028 Reset mid-operation discards all shadow state; first post-reset ID instruction sees no forwarding.
REQ-029 stall reads 0 during and immediately after reset.

Configuration
REQ-030 Macro FWD_STATS_EN defined: stall_cnt increments per stall cycle, fwd_cnt per registered instruction with any nonzero select; both saturate at 16'hFFFF.
REQ-031 Macro FWD_STATS_EN undefined: counters and their ports absent; all other behaviour identical.

Structure
REQ-032 Shared package holds select-code constants (SEL_RF, SEL_S1, SEL_S2, SEL_S3) and shadow-slot record type.
REQ-033 One sub-module, fwd_match, compares one source against three slots and returns select plus load-hit; instantiated twice.

Verification
REQ-034 S1={add,$5}, ID reads rs=$5 -> next cycle sel_a=1, sel_b=0, mux_dis=0, stall never 1.
REQ-035 S1={lw,$8}, ID rt=$8 used -> stall=1 one cycle, then mux_dis=1 for bubble, then sel_b=2.
REQ-036 S1,S2,S3 all write $3, ID rs=$3 -> sel_a=1 (youngest wins).
REQ-037 S1 writes $0, ID rs=$0 -> sel_a=0; load writing $0 -> no stall.
REQ-038 Load-use hazard with flush=1 same cycle -> stall=0, next sel=0, mux_dis=1.
REQ-039 rst_n low during a stall -> next cycle stall=0, mux_dis=1, all selects 0.
